fetch_decode_stage: RTL and testbench
=====================================

// Module: fetch_decode_stage
// PURPOSE
//  IF stage + IF/ID pipeline register of the 5-stage RISC pipeline; directly upstream of the control unit.
//  Owns the PC, reads instruction memory, and registers instruction and PC into IF/ID.
//  Presents the opcode and register fields to ID, and drives the control unit's ST input with a bubble request.
//  A run FSM starts on a pulse, fetches PROG_LEN words, drains the pipeline, then flags done.
// PARAMETERS
//  IW        16  instruction width; opcode = instr[IW-1:IW-4]
//  AW        8   PC / instruction-memory address width (word addressed)
//  PROG_LEN  16  number of instructions fetched per run; 1..2**AW
//  DRAIN     4   cycles spent in DRAIN after the last fetch (remaining stages)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous reset, active high
//  start      in   1   run request pulse; honoured only in IDLE or DONE
//  stall_in   in   1   hazard stall from downstream: hold PC and IF/ID
//  im_en      out  1   instruction-memory enable (= EnIM role; high while fetching)
//  im_addr    out  AW  instruction-memory address (= PC)
//  im_rdata   in   IW  instruction word, combinational read of im_addr
//  if_id_pc   out  AW  PC of the instruction held in IF/ID
//  if_id_valid out 1   IF/ID holds a real instruction
//  opcode     out  4   if_id_instr[IW-1:IW-4]
//  rd         out  4   if_id_instr[11:8]
//  rs         out  4   if_id_instr[7:4]
//  rt_imm     out  4   if_id_instr[3:0] (rt, or imm for SW/SUBI)
//  ctrl_st    out  1   ST to control unit = stall_in | ~if_id_valid (combinational)
//  busy       out  1   state is RUN or DRAIN
//  done       out  1   registered; high in DONE until the next start
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, pc=0, if_id_instr=0, if_id_pc=0, if_id_valid=0,
//   drain_cnt=0, done=0; hence im_en=0, ctrl_st=1, busy=0.
//  FSM: IDLE -start-> RUN; RUN -last fetch accepted-> DRAIN; DRAIN -drain_cnt==DRAIN-1 & !stall_in-> DONE;
//   DONE -start-> RUN (pc cleared to 0, done cleared). start in RUN/DRAIN is ignored.
//  RUN, stall_in=0: IF/ID <= {im_rdata, pc}, valid<=1, pc<=pc+1. Latency: word at addr N
//   appears on opcode/rd/rs/rt_imm one cycle after im_addr==N.
//  RUN, stall_in=1: pc, if_id_* all hold; im_en stays 1 (re-read is harmless).
//  Last fetch = accepted fetch with pc==PROG_LEN-1; pc is not incremented past it (no wrap, even when PROG_LEN==2**AW).
//  DRAIN: im_en=0; at first non-stalled edge valid<=0 (bubble), instr held;
//   drain_cnt increments only on non-stalled cycles; cleared on DRAIN entry.
//  IDLE/DONE: im_en=0, valid=0, pc holds.
//  Stall on the last-fetch cycle: FSM stays in RUN until the fetch is accepted.
//  start with stall_in=1 in IDLE: FSM enters RUN; first fetch is accepted once the stall drops.
//  ctrl_st high whenever IF/ID is a bubble, so the control unit emits its NOP controls (EnRW=0, MW=0).
//  Reset asserted mid-run: everything returns to reset values asynchronously; no partial state survives.
// STRUCTURE
//  Shared package: opcode constants (OP_SW=4'b0000, OP_ADD=4'b0001, OP_OR=4'b0011,
//   OP_SUBI=4'b0111, OP_NAND=4'b1111), field bit positions, FSM state encoding (IDLE/RUN/DRAIN/DONE).
//  One sub-module: if_id_reg (IW+AW+1 bit register with hold and bubble controls, async reset);
//   the PC, FSM and drain counter stay in this module.
// TESTING
//  1 Reset mid-RUN at pc=5 -> next cycle: pc=0, valid=0, ctrl_st=1, done=0, state IDLE.
//  2 PROG_LEN=4, memory {0x1123,0x3456,0x7A01,0x0B02}, start, no stall -> opcodes 1,3,7,0 appear on
//    cycles 2..5 after start with if_id_pc 0..3; done rises DRAIN+1 cycles after the last fetch; im_en=0 after.
//  3 stall_in high 3 cycles while if_id_pc=1 -> pc, opcode and if_id_pc frozen; ctrl_st=1 during stall; sequence resumes unchanged.
//  4 stall on the last fetch and during DRAIN -> no extra fetch, pc stays PROG_LEN-1; done delayed by exactly the stalled cycles.
//  5 start pulsed during RUN, then again in DONE -> first ignored; second restarts from pc=0 and clears done.
//  6 PROG_LEN=2**AW (AW=4, 16 words) -> 16 fetches, pc never wraps to 0, single done.

Source files
------------

// File: rtl/fetch_decode_stage_pkg.sv
// Shared definitions for the IF stage: opcode values, instruction field
// positions and the run FSM state encoding.
package fetch_decode_stage_pkg;

    localparam logic [3:0] OP_SW   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SUBI = 4'b0111;
    localparam logic [3:0] OP_NAND = 4'b1111;

    // Register fields are 4 bits wide; field 0 is rt/imm, 1 is rs, 2 is rd.
    localparam int FIELD_W  = 4;
    localparam int N_FIELDS = 3;
    localparam int OPC_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fds_state_e;

endpackage

// File: rtl/fetch_decode_stage_if_id_reg.sv
// IF/ID pipeline register: {instr, pc, valid} with hold (stall) and
// bubble (valid cleared, payload kept) controls.
module if_id_reg
    import fetch_decode_stage_pkg::*;
#(
    parameter int IW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold_i,
    input  logic          bubble_i,
    input  logic [IW-1:0] instr_i,
    input  logic [AW-1:0] pc_i,
    output logic [IW-1:0] instr_o,
    output logic [AW-1:0] pc_o,
    output logic          valid_o
);

    logic [IW+AW:0] data_q, data_d;

    // hold wins over bubble so a stalled bubble keeps whatever valid it had
    always_comb begin
        data_d = data_q;
        if (!hold_i) begin
            if (bubble_i) begin
                data_d[0] = 1'b0;
            end else begin
                data_d = {instr_i, pc_i, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign instr_o = data_q[IW+AW:AW+1];
    assign pc_o    = data_q[AW:1];
    assign valid_o = data_q[0];

endmodule

// File: rtl/fetch_decode_stage.sv
// IF stage: PC, run FSM and drain counter, feeding the IF/ID register and
// presenting decoded fields plus a bubble/stall request to the control unit.
module fetch_decode_stage
    import fetch_decode_stage_pkg::*;
#(
    parameter int IW       = 16,
    parameter int AW       = 8,
    parameter int PROG_LEN = 16,
    parameter int DRAIN    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stall_in,
    output logic          im_en,
    output logic [AW-1:0] im_addr,
    input  logic [IW-1:0] im_rdata,
    output logic [AW-1:0] if_id_pc,
    output logic          if_id_valid,
    output logic [3:0]    opcode,
    output logic [3:0]    rd,
    output logic [3:0]    rs,
    output logic [3:0]    rt_imm,
    output logic          ctrl_st,
    output logic          busy,
    output logic          done
);

    localparam int             DCW        = $clog2(DRAIN + 1);
    localparam logic [AW-1:0]  LAST_PC    = AW'(PROG_LEN - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN - 1);

    fds_state_e     state_q;
    logic [AW-1:0]  pc_q;
    logic [DCW-1:0] drain_cnt_q;
    logic           done_q;

    logic           fetching;
    logic [IW-1:0]  ifid_instr;
    logic [FIELD_W-1:0] field [N_FIELDS];

    assign fetching = (state_q == ST_RUN);
    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    // The last fetch parks the PC at LAST_PC so it never wraps, even when
    // PROG_LEN fills the whole address space.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        pc_q    <= '0;
                        done_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!stall_in) begin
                        if (pc_q == LAST_PC) begin
                            state_q     <= ST_DRAIN;
                            drain_cnt_q <= '0;
                        end else begin
                            pc_q <= pc_q + AW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!stall_in) begin
                        if (drain_cnt_q == DRAIN_LAST) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + DCW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    if_id_reg #(
        .IW (IW),
        .AW (AW)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .hold_i   (stall_in & busy),
        .bubble_i (~fetching),
        .instr_i  (im_rdata),
        .pc_i     (pc_q),
        .instr_o  (ifid_instr),
        .pc_o     (if_id_pc),
        .valid_o  (if_id_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_FIELDS; gi++) begin : g_field
            assign field[gi] = ifid_instr[gi*FIELD_W +: FIELD_W];
        end
    endgenerate

    assign opcode  = ifid_instr[IW-1 -: OPC_W];
    assign rd      = field[2];
    assign rs      = field[1];
    assign rt_imm  = field[0];
    assign im_en   = fetching;
    assign im_addr = pc_q;
    assign done    = done_q;
    assign ctrl_st = stall_in | ~if_id_valid;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: a short-program instance (PROG_LEN=4) and a
// full-address-space instance (AW=4, PROG_LEN=16), checked against a progress-count model.
module tb_fetch_decode_stage;

    logic clk = 1'b0;
    logic rst;
    logic start_a, stall_a, start_b, stall_b;
    always #5 clk = ~clk;

    logic [15:0] mem [256];

    logic        im_en_a, valid_a, cst_a, busy_a, done_a;
    logic [7:0]  im_addr_a, ifpc_a;
    logic [15:0] rdata_a;
    logic [3:0]  opc_a, rd_a, rs_a, rt_a;

    logic        im_en_b, valid_b, cst_b, busy_b, done_b;
    logic [3:0]  im_addr_b, ifpc_b;
    logic [15:0] rdata_b;
    logic [3:0]  opc_b, rd_b, rs_b, rt_b;

    assign rdata_a = mem[im_addr_a];
    assign rdata_b = mem[{4'b0, im_addr_b}];

    fetch_decode_stage #(.IW(16), .AW(8), .PROG_LEN(4), .DRAIN(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stall_in(stall_a),
        .im_en(im_en_a), .im_addr(im_addr_a), .im_rdata(rdata_a),
        .if_id_pc(ifpc_a), .if_id_valid(valid_a), .opcode(opc_a), .rd(rd_a),
        .rs(rs_a), .rt_imm(rt_a), .ctrl_st(cst_a), .busy(busy_a), .done(done_a)
    );

    fetch_decode_stage #(.IW(16), .AW(4), .PROG_LEN(16), .DRAIN(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stall_in(stall_b),
        .im_en(im_en_b), .im_addr(im_addr_b), .im_rdata(rdata_b),
        .if_id_pc(ifpc_b), .if_id_valid(valid_b), .opcode(opc_b), .rd(rd_b),
        .rs(rs_b), .rt_imm(rt_b), .ctrl_st(cst_b), .busy(busy_b), .done(done_b)
    );

    // Observed view of whichever instance is under test.
    logic        sel;
    logic        o_en, o_valid, o_cst, o_busy, o_done;
    logic [7:0]  o_addr, o_ifpc;
    logic [15:0] o_word;
    assign o_en    = sel ? im_en_b : im_en_a;
    assign o_valid = sel ? valid_b : valid_a;
    assign o_cst   = sel ? cst_b   : cst_a;
    assign o_busy  = sel ? busy_b  : busy_a;
    assign o_done  = sel ? done_b  : done_a;
    assign o_addr  = sel ? {4'b0, im_addr_b} : im_addr_a;
    assign o_ifpc  = sel ? {4'b0, ifpc_b}    : ifpc_a;
    assign o_word  = sel ? {opc_b, rd_b, rs_b, rt_b} : {opc_a, rd_a, rs_a, rt_a};

    int total = 0;
    int bad   = 0;

    // Model: k counts non-stalled cycles since the accepted start. Fetch k
    // happens while k < P, the pipe drains for D more cycles, then done.
    int P, D;
    bit m_act, m_done, m_any;
    int m_k, m_idle_pc, m_last;
    bit cur_st, cur_sl;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_done = 0; m_any = 0;
        m_k = 0; m_idle_pc = 0; m_last = 0;
    endtask

    task automatic model_edge(input bit st, input bit sl);
        if (m_act) begin
            if (!sl) begin
                if (m_k < P) begin
                    m_last = m_k;
                    m_any  = 1;
                end
                m_k++;
                if (m_k == P + D) begin
                    m_act     = 0;
                    m_done    = 1;
                    m_idle_pc = P - 1;
                end
            end
        end else if (st) begin
            m_act  = 1;
            m_k    = 0;
            m_done = 0;
        end
    endtask

    task automatic check_model();
        bit v;
        int pcx;
        logic [15:0] w;
        v   = m_act && (m_k >= 1) && (m_k <= P);
        pcx = m_act ? ((m_k < P) ? m_k : P - 1) : m_idle_pc;
        w   = m_any ? mem[m_last] : 16'h0000;
        chk("busy",     32'(o_busy),  32'(m_act));
        chk("im_en",    32'(o_en),    32'(m_act && (m_k < P)));
        chk("im_addr",  32'(o_addr),  32'(pcx));
        chk("valid",    32'(o_valid), 32'(v));
        chk("if_id_pc", 32'(o_ifpc),  32'(m_last));
        chk("fields",   32'(o_word),  32'(w));
        chk("ctrl_st",  32'(o_cst),   32'(cur_sl || !v));
        chk("done",     32'(o_done),  32'(m_done));
    endtask

    task automatic apply(input bit st, input bit sl);
        cur_st = st;
        cur_sl = sl;
        start_a = sel ? 1'b0 : st;
        stall_a = sel ? 1'b0 : sl;
        start_b = sel ? st : 1'b0;
        stall_b = sel ? sl : 1'b0;
        #1;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(cur_st, cur_sl);
        #1;
    endtask

    task automatic step(input bit st, input bit sl);
        apply(st, sl);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_dut(input bit s);
        sel = s;
        P = s ? 16 : 4;
        D = 4;
        start_a = 0; stall_a = 0; start_b = 0; stall_b = 0;
        cur_st = 0; cur_sl = 0;
        do_reset();
    endtask

    typedef struct {
        bit          st;
        bit          sl;
        bit          en;
        logic [7:0]  addr;
        bit          v;
        logic [7:0]  ipc;
        logic [15:0] w;
        bit          busy;
        bit          done;
    } vec_t;

    vec_t tbl [11];
    int   done_c, fetches, rises;
    bit   prev_done, sl;

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        start_a = 0; stall_a = 0; start_b = 0; stall_b = 0;
        cur_st = 0; cur_sl = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        P = 4; D = 4;
        model_reset();
        @(posedge clk);
        #1;

        // Reset asserted mid-run with pc=5 on the 16-word instance.
        set_dut(1'b1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        apply(1'b0, 1'b0);
        chk("t1_pc_before", 32'(o_addr), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_pc",      32'(o_addr),  32'd0);
        chk("t1_valid",   32'(o_valid), 32'd0);
        chk("t1_ctrl_st", 32'(o_cst),   32'd1);
        chk("t1_done",    32'(o_done),  32'd0);
        chk("t1_busy",    32'(o_busy),  32'd0);
        chk("t1_im_en",   32'(o_en),    32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0);
        $display("test1: reset mid-run returned to idle");

        // Fixed program, no stall, table-driven.
        mem[0] = 16'h1123; mem[1] = 16'h3456; mem[2] = 16'h7A01; mem[3] = 16'h0B02;
        set_dut(1'b0);
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 8'd0, 16'h1123, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 8'd1, 16'h3456, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 8'd2, 16'h7A01, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'd3, 1'b1, 8'd3, 16'h0B02, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 8'd3, 16'h0B02, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 8'd3, 16'h0B02, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 8'd3, 16'h0B02, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 8'd3, 16'h0B02, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 8'd3, 16'h0B02, 1'b0, 1'b1};
        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].st, tbl[i].sl);
            chk("tv_im_en",   32'(o_en),    32'(tbl[i].en));
            chk("tv_im_addr", 32'(o_addr),  32'(tbl[i].addr));
            chk("tv_valid",   32'(o_valid), 32'(tbl[i].v));
            chk("tv_if_pc",   32'(o_ifpc),  32'(tbl[i].ipc));
            chk("tv_fields",  32'(o_word),  32'(tbl[i].w));
            chk("tv_ctrl_st", 32'(o_cst),   32'(tbl[i].sl || !tbl[i].v));
            chk("tv_busy",    32'(o_busy),  32'(tbl[i].busy));
            chk("tv_done",    32'(o_done),  32'(tbl[i].done));
            $display("vec %0d: start=%0d stall=%0d addr=%0d if_id_pc=%0d word=%04h done=%0d",
                     i, tbl[i].st, tbl[i].sl, o_addr, o_ifpc, o_word, o_done);
            tick();
        end

        // Three stalled cycles while IF/ID holds pc 1.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1);
            chk("t3_pc",      32'(o_addr), 32'd2);
            chk("t3_if_pc",   32'(o_ifpc), 32'd1);
            chk("t3_word",    32'(o_word), 32'h3456);
            chk("t3_ctrl_st", 32'(o_cst),  32'd1);
            tick();
        end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        $display("test3: stall while if_id_pc=1 held the pipe");

        // Stall on the last fetch (2 cycles) and in DRAIN (3 cycles).
        done_c = -1;
        step(1'b1, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            sl = (c == 4) || (c == 5) || (c == 8) || (c == 9) || (c == 10);
            apply(1'b0, sl);
            if (c == 4 || c == 5) begin
                chk("t4_last_addr", 32'(o_addr), 32'd3);
                chk("t4_last_en",   32'(o_en),   32'd1);
            end
            if (c >= 8 && c <= 10) chk("t4_drain_en", 32'(o_en), 32'd0);
            if (o_done && done_c < 0) done_c = c;
            tick();
        end
        chk("t4_done_cycle", 32'(done_c), 32'd14);
        $display("test4: done at cycle %0d after start", done_c);

        // start during RUN is ignored; start in DONE restarts.
        done_c = -1;
        step(1'b1, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            apply(c == 2, 1'b0);
            if (o_done && done_c < 0) done_c = c;
            tick();
        end
        chk("t5_done_cycle", 32'(done_c), 32'd9);
        step(1'b1, 1'b0);
        apply(1'b0, 1'b0);
        chk("t5_busy",    32'(o_busy), 32'd1);
        chk("t5_done",    32'(o_done), 32'd0);
        chk("t5_im_addr", 32'(o_addr), 32'd0);
        tick();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        $display("test5: start in RUN ignored, start in DONE restarted");

        // Full address space: 16 fetches, single done.
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        set_dut(1'b1);
        fetches = 0;
        rises = 0;
        prev_done = 0;
        step(1'b1, 1'b0);
        for (int c = 1; c <= 100; c++) begin
            sl = ($urandom % 4) == 0;
            apply(1'b0, sl);
            if (o_en && !sl) fetches++;
            if (o_done && !prev_done) rises++;
            prev_done = o_done;
            tick();
        end
        chk("t6_fetches", 32'(fetches), 32'd16);
        chk("t6_rises",   32'(rises),   32'd1);
        chk("t6_done",    32'(o_done),  32'd1);
        $display("test6: %0d fetches, %0d done rise(s)", fetches, rises);

        // Random start/stall/reset against the model on both instances.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
            set_dut(s[0]);
            for (int i = 0; i < 400; i++) begin
                if (($urandom % 100) == 0) do_reset();
                step(($urandom % 8) == 0, ($urandom % 4) == 0);
            end
            $display("random run on instance %0d: total so far=%0d", s, total);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
